// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between NUM_REQ requesters.
// Optional ALU_ARB_PERF_EN adds per-requester grant and wait counters.
module alu_share_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int XLEN    = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [4*NUM_REQ-1:0]    req_op,
    input  logic [XLEN*NUM_REQ-1:0] req_a,
    input  logic [XLEN*NUM_REQ-1:0] req_b,
    output logic [3:0]              alu_ctrl,
    output logic [XLEN-1:0]         alu_a,
    output logic [XLEN-1:0]         alu_b,
    input  logic [XLEN-1:0]         alu_result,
    output logic [NUM_REQ-1:0]      rsp_valid,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic [XLEN-1:0]         rsp_data
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [32*NUM_REQ-1:0]   perf_grant_cnt,
    output logic [32*NUM_REQ-1:0]   perf_wait_cnt
`endif
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t        state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] gnt_q;
    logic [IW-1:0] gnt_idx;
    logic [IW-1:0] ptr_next;
    logic [IW:0]   cand;
    logic          gnt_found;
    logic          accept;

    // Scan offsets from farthest to nearest so the requester closest to ptr wins.
    // NOTE: every variable gets a default first so no latch is inferred.
    always_comb begin
        gnt_idx   = ptr;
        gnt_found = 1'b0;
        cand      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(NUM_REQ)) begin
                cand = cand - (IW+1)'(NUM_REQ);
            end
            if (req_valid[cand[IW-1:0]]) begin
                gnt_idx   = cand[IW-1:0];
                gnt_found = 1'b1;
            end
        end
    end

    assign accept   = (state == IDLE) && gnt_found;
    assign ptr_next = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt_q     <= '0;
            alu_ctrl  <= 4'b0000;
            alu_a     <= '0;
            alu_b     <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        gnt_q    <= gnt_idx;
                        alu_ctrl <= req_op[gnt_idx*4 +: 4];
                        alu_a    <= req_a[gnt_idx*XLEN +: XLEN];
                        alu_b    <= req_b[gnt_idx*XLEN +: XLEN];
                        ptr      <= ptr_next;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= alu_result;
                    rsp_valid <= NUM_REQ'(1) << gnt_q;
                    state     <= RESP;
                end
                RESP: begin
                    // Only the granted requester's rsp_ready completes the handshake.
                    if (rsp_ready[gnt_q]) begin
                        rsp_valid <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_ARB_PERF_EN
    logic [31:0] grant_cnt [NUM_REQ];
    logic [31:0] wait_cnt  [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_perf
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                grant_cnt[i] <= '0;
                wait_cnt[i]  <= '0;
            end else begin
                if (req_ready[i]) begin
                    grant_cnt[i] <= grant_cnt[i] + 32'd1;
                end
                if (req_valid[i] && !req_ready[i]) begin
                    wait_cnt[i] <= wait_cnt[i] + 32'd1;
                end
            end
        end
        assign perf_grant_cnt[32*i +: 32] = grant_cnt[i];
        assign perf_wait_cnt[32*i +: 32]  = wait_cnt[i];
    end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter with a small behavioural ALU model.
// Perf counter checks are compiled in when ALU_ARB_PERF_EN is defined.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [7:0]  req_op;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_data;
`ifdef ALU_ARB_PERF_EN
    logic [63:0] perf_grant_cnt;
    logic [63:0] perf_wait_cnt;
`endif

    int total = 0;
    int bad   = 0;

    alu_share_arbiter #(.NUM_REQ(2), .XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .alu_ctrl   (alu_ctrl),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data)
`ifdef ALU_ARB_PERF_EN
        ,
        .perf_grant_cnt (perf_grant_cnt),
        .perf_wait_cnt  (perf_wait_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference ALU: ADD, SUB, AND, OR; anything else XOR so forwarded odd encodings are visible.
    always_comb begin
        case (alu_ctrl)
            4'b0000: alu_result = alu_a + alu_b;
            4'b1000: alu_result = alu_a - alu_b;
            4'b0111: alu_result = alu_a & alu_b;
            4'b0110: alu_result = alu_a | alu_b;
            default: alu_result = alu_a ^ alu_b;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Entered 1ns after a negedge in IDLE with the request already driven; returns at the next IDLE.
    task automatic run_op(input string tag, input logic [1:0] exp_gnt,
                          input logic [31:0] exp_data, input logic [3:0] exp_ctrl);
        check({tag, "_ready"}, 32'(req_ready), 32'(exp_gnt));
        @(negedge clk); #1;
        check({tag, "_exec_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_exec_rspv"},  32'(rsp_valid), 32'd0);
        check({tag, "_exec_ctrl"},  32'(alu_ctrl),  32'(exp_ctrl));
        @(negedge clk); #1;
        check({tag, "_rspv"}, 32'(rsp_valid), 32'(exp_gnt));
        check({tag, "_data"}, rsp_data, exp_data);
        @(negedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_alu_ctrl",  32'(alu_ctrl),  32'd0);
        check("rst_alu_a",     alu_a,          32'd0);
        check("rst_alu_b",     alu_b,          32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data",  rsp_data,       32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("idle_req_ready", 32'(req_ready), 32'd0);
        check("idle_rsp_valid", 32'(rsp_valid), 32'd0);

        // Single request from requester 0: 5 + 7
        req_op[3:0]  = 4'b0000;
        req_a[31:0]  = 32'd5;
        req_b[31:0]  = 32'd7;
        req_valid    = 2'b01;
        #1;
        run_op("single", 2'b01, 32'd12, 4'b0000);
        req_valid = 2'b00;
        #1;
        check("single_drop_ready", 32'(req_ready), 32'd0);
        check("single_hold_a",     alu_a,          32'd5);
        check("single_hold_b",     alu_b,          32'd7);

        // Both requesting continuously: 10 - 3, grants alternate 0,1,0,1
        reset_dut();
        req_op = {4'b1000, 4'b1000};
        req_a  = {32'd10, 32'd10};
        req_b  = {32'd3, 32'd3};
        req_valid = 2'b11;
        #1;
        for (int i = 0; i < 4; i++) begin
            run_op("rr", (i % 2 == 0) ? 2'b01 : 2'b10, 32'd7, 4'b1000);
        end

        // Different ops per requester, including an unused encoding on requester 1
        req_op = {4'b1001, 4'b0111};
        req_a  = {32'h0000_000F, 32'h0000_F0F0};
        req_b  = {32'h0000_00FF, 32'h0000_FF00};
        run_op("mix_and", 2'b01, 32'h0000_F000, 4'b0111);
        run_op("mix_odd", 2'b10, 32'h0000_00F0, 4'b1001);
        req_valid = 2'b00;

        // Response back-pressure on requester 0; requester 1 waits, its rsp_ready ignored
        reset_dut();
        req_op    = {4'b1000, 4'b0000};
        req_a     = {32'd50, 32'd100};
        req_b     = {32'd8, 32'd23};
        req_valid = 2'b11;
        rsp_ready = 2'b10;
        #1;
        check("stall_ready", 32'(req_ready), 32'd1);
        @(negedge clk); #1;
        @(negedge clk); #1;
        check("stall_rspv0", 32'(rsp_valid), 32'd1);
        check("stall_data0", rsp_data, 32'd123);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            check("stall_rspv",  32'(rsp_valid), 32'd1);
            check("stall_data",  rsp_data,       32'd123);
            check("stall_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 2'b01;
        @(negedge clk); #1;
        req_valid = 2'b10;
        rsp_ready = 2'b11;
        #1;
        run_op("stall_req1", 2'b10, 32'd42, 4'b1000);
        req_valid = 2'b00;

        // Reset during EXEC drops the op; arbitration restarts at requester 0
        reset_dut();
        req_op    = {4'b1000, 4'b0000};
        req_a     = {32'd10, 32'd1};
        req_b     = {32'd3, 32'd2};
        req_valid = 2'b01;
        #1;
        check("rexec_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = 2'b00;
        #1;
        check("rexec_alu_a",  alu_a,          32'd0);
        check("rexec_alu_b",  alu_b,          32'd0);
        check("rexec_ctrl",   32'(alu_ctrl),  32'd0);
        check("rexec_rspv",   32'(rsp_valid), 32'd0);
        check("rexec_data",   rsp_data,       32'd0);
        check("rexec_rready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("rexec_norsp", 32'(rsp_valid), 32'd0);
        end
        req_op    = {4'b1000, 4'b1000};
        req_a     = {32'd10, 32'd10};
        req_b     = {32'd3, 32'd3};
        req_valid = 2'b11;
        #1;
        run_op("rexec_regrant", 2'b01, 32'd7, 4'b1000);
        req_valid = 2'b00;

`ifdef ALU_ARB_PERF_EN
        // Requester 1 requests three ops back to back: 3 grants, 4 waiting cycles
        reset_dut();
        req_op    = {4'b0000, 4'b0000};
        req_a     = {32'd2, 32'd0};
        req_b     = {32'd3, 32'd0};
        req_valid = 2'b10;
        #1;
        run_op("perf_op1", 2'b10, 32'd5, 4'b0000);
        run_op("perf_op2", 2'b10, 32'd5, 4'b0000);
        check("perf_op3_ready", 32'(req_ready), 32'd2);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk); #1;
        check("perf_op3_data", rsp_data, 32'd5);
        @(negedge clk); #1;
        check("perf_grant1", perf_grant_cnt[63:32], 32'd3);
        check("perf_wait1",  perf_wait_cnt[63:32],  32'd4);
        check("perf_grant0", perf_grant_cnt[31:0],  32'd0);
        check("perf_wait0",  perf_wait_cnt[31:0],   32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
